// File: rtl/alu_ops_pkg.sv
// Shared ALU opcode definitions used by every block that drives the ALU.
// ALU_SHL shifts operand A left by one bit. Operand B is ignored for that opcode.
package alu_ops_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_PASSA = 4'h0;
    localparam alu_op_t ALU_ADD   = 4'h1;
    localparam alu_op_t ALU_SUB   = 4'h2;
    localparam alu_op_t ALU_AND   = 4'h3;
    localparam alu_op_t ALU_OR    = 4'h4;
    localparam alu_op_t ALU_XOR   = 4'h5;
    localparam alu_op_t ALU_SHL   = 4'h6;
    localparam alu_op_t ALU_SHR   = 4'h7;

endpackage

// File: rtl/alu_seq_pkg.sv
// State encoding shared by the ALU-driving sequencers.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier that borrows an external ALU for both the accumulate and the shift.
// Only the low WIDTH bits of the product are kept.
module alu_mul_seq
    import alu_ops_pkg::*;
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic [3:0]       alu_op,
    output logic             alu_oe,
    output logic             alu_carry,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CNT_W = ($clog2(WIDTH) + 1 < 5) ? 5 : $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_shr;

    assign q_shr = q_q >> 1;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        alu_op  = ALU_PASSA;
        alu_oe  = 1'b0;
        alu_a   = '0;
        alu_b   = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d   = a_in;
                    q_d   = b_in;
                    p_d   = '0;
                    cnt_d = '0;
                    if (b_in == '0) begin
                        state_d = DONE;
                    end else if (b_in[0]) begin
                        state_d = ADD;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            ADD: begin
                alu_op  = ALU_ADD;
                alu_oe  = 1'b1;
                alu_a   = p_q;
                alu_b   = m_q;
                p_d     = alu_result;
                state_d = SHIFT;
            end
            SHIFT: begin
                alu_op = ALU_SHL;
                alu_oe = 1'b1;
                alu_a  = m_q;
                m_d    = alu_result;
                q_d    = q_shr;
                cnt_d  = cnt_q + CNT_W'(1);
                // Zero-run skipping: leave as soon as no multiplier bits remain.
                if (q_shr == '0 || cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else if (q_shr[0]) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
        end
    end

    // P only moves between an accepted start and DONE, so it doubles as the held product.
    assign product   = p_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign alu_carry = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU on the shared opcode set.
module tb_alu_mul_seq;
    import alu_ops_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [3:0]  alu_op;
    logic        alu_oe;
    logic        alu_carry;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    int n_checks = 0;
    int n_errors = 0;

    alu_mul_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .alu_op     (alu_op),
        .alu_oe     (alu_oe),
        .alu_carry  (alu_carry),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_PASSA: alu_result = alu_a;
            ALU_ADD:   alu_result = alu_a + alu_b;
            ALU_SUB:   alu_result = alu_a - alu_b;
            ALU_AND:   alu_result = alu_a & alu_b;
            ALU_OR:    alu_result = alu_a | alu_b;
            ALU_XOR:   alu_result = alu_a ^ alu_b;
            ALU_SHL:   alu_result = alu_a << 1;
            ALU_SHR:   alu_result = alu_a >> 1;
            default:   alu_result = '0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_oe"}, 64'(alu_oe), 64'd0);
        check({tag, "_op"}, 64'(alu_op), 64'(ALU_PASSA));
        check({tag, "_ab"}, {alu_a, alu_b}, 64'd0);
    endtask

    // Accept edge happens inside; returns in cycle 1 after accept.
    task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called while in cycle k0 after the accept edge; runs to DONE and one cycle beyond.
    task automatic wait_done(input string tag, input int k0, input int exp_cycles,
                             input logic [31:0] exp_prod,
                             output int n_add, output int n_shl, output logic oe_seen);
        int k;
        k       = k0;
        n_add   = 0;
        n_shl   = 0;
        oe_seen = 1'b0;
        while (done !== 1'b1 && k < 200) begin
            if (alu_oe) oe_seen = 1'b1;
            if (alu_oe && alu_op == ALU_ADD) n_add++;
            if (alu_oe && alu_op == ALU_SHL) n_shl++;
            tick();
            k++;
        end
        if (alu_oe) oe_seen = 1'b1;
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_latency"}, 64'(k), 64'(exp_cycles));
        check({tag, "_product"}, 64'(product), 64'(exp_prod));
        check({tag, "_carry"}, 64'(alu_carry), 64'd0);
        tick();
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_held"}, 64'(product), 64'(exp_prod));
    endtask

    initial begin
        int   n_add;
        int   n_shl;
        logic oe_seen;

        clk   = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        rst = 1'b0;
        check_idle_outputs("reset");
        check("reset_product", 64'(product), 64'd0);
        check("reset_carry", 64'(alu_carry), 64'd0);
        tick();
        check_idle_outputs("idle_no_start");

        // 3*5: ADD, SHIFT, SHIFT, ADD, SHIFT, then DONE in cycle 6.
        start_mul(32'd3, 32'd5);
        check("m35_c1_op", 64'(alu_op), 64'(ALU_ADD));
        check("m35_c1_ab", {alu_a, alu_b}, {32'd0, 32'd3});
        check("m35_c1_busy", 64'(busy), 64'd1);
        tick();
        check("m35_c2_op", 64'(alu_op), 64'(ALU_SHL));
        check("m35_c2_ab", {alu_a, alu_b}, {32'd3, 32'd0});
        tick();
        check("m35_c3_op", 64'(alu_op), 64'(ALU_SHL));
        check("m35_c3_a", 64'(alu_a), 64'd6);
        tick();
        check("m35_c4_op", 64'(alu_op), 64'(ALU_ADD));
        check("m35_c4_ab", {alu_a, alu_b}, {32'd3, 32'd12});
        tick();
        check("m35_c5_op", 64'(alu_op), 64'(ALU_SHL));
        check("m35_c5_oe", 64'(alu_oe), 64'd1);
        check("m35_c5_done", 64'(done), 64'd0);
        tick();
        wait_done("m35", 6, 6, 32'd15, n_add, n_shl, oe_seen);

        // Zero multiplier goes straight to DONE with the ALU untouched.
        start_mul(32'd7, 32'd0);
        wait_done("m70", 1, 1, 32'd0, n_add, n_shl, oe_seen);
        check("m70_oe_seen", 64'(oe_seen), 64'd0);

        // All-ones multiplier: every bit costs an ADD and a SHIFT.
        start_mul(32'd1, 32'hFFFF_FFFF);
        wait_done("mff", 1, 65, 32'hFFFF_FFFF, n_add, n_shl, oe_seen);
        check("mff_adds", 64'(n_add), 64'd32);
        check("mff_shifts", 64'(n_shl), 64'd32);

        // Multiplicand shifts off the top: product wraps to 0.
        start_mul(32'h8000_0000, 32'd2);
        wait_done("mwrap0", 1, 4, 32'd0, n_add, n_shl, oe_seen);

        // Carry out of the adder is dropped: 0xFFFFFFFF*3 = 0x2_FFFFFFFD.
        start_mul(32'hFFFF_FFFF, 32'd3);
        wait_done("mwrap1", 1, 5, 32'hFFFF_FFFD, n_add, n_shl, oe_seen);

        // A second start while busy must not disturb the running 3*5.
        start_mul(32'd3, 32'd5);
        a_in  = 32'd9;
        b_in  = 32'd9;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check("ign_busy", 64'(busy), 64'd1);
        wait_done("ign", 3, 6, 32'd15, n_add, n_shl, oe_seen);

        // Reset in the middle of a run, while SHIFT is active.
        start_mul(32'd3, 32'd5);
        tick();
        check("rst_pre_op", 64'(alu_op), 64'(ALU_SHL));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("rst_mid");
        check("rst_mid_product", 64'(product), 64'd0);

        // Reset wins over a simultaneous start.
        a_in  = 32'd6;
        b_in  = 32'd7;
        start = 1'b1;
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check_idle_outputs("rst_prio");
        tick();
        check("rst_prio_stay", 64'(busy), 64'd0);

        start_mul(32'd6, 32'd7);
        wait_done("m67", 1, 7, 32'd42, n_add, n_shl, oe_seen);
        check("m67_adds", 64'(n_add), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
